// File: rtl/arm_core_pkg.sv
// Shared core definitions used by the multiply unit and the instruction decoder.
//   mul_state_t     : multiply unit FSM states
//   MUL_BIT_*       : bit positions of the long / signed / accumulate / S fields
//                     within a multiply instruction word
package arm_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        FINAL = 2'd2
    } mul_state_t;

    localparam int unsigned MUL_BIT_LONG   = 23;
    localparam int unsigned MUL_BIT_SIGNED = 22;
    localparam int unsigned MUL_BIT_ACC    = 21;
    localparam int unsigned MUL_BIT_S      = 20;

endpackage

// File: rtl/mul_step.sv
// One radix step of the iterative multiplier (purely combinational).
//   p, rm_ext  : running 2*WIDTH product and extended multiplicand
//   rs         : multiplier
//   iter       : chunk index i
//   sign_mode  : allow early termination on a run of ones
//   p_next     : p + rm_ext * chunk_i << (RADIX_BITS*i)
//   last       : this is the final iteration
//   shift      : RADIX_BITS*(i+1), weight of the first unconsumed bit
module mul_step
    import arm_core_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 8,
    localparam int unsigned N_ITER    = WIDTH / RADIX_BITS,
    localparam int unsigned IW        = (N_ITER > 1) ? $clog2(N_ITER) : 1,
    localparam int unsigned SW        = $clog2(WIDTH + 1)
) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [2*WIDTH-1:0] rm_ext,
    input  logic [WIDTH-1:0]   rs,
    input  logic [IW-1:0]      iter,
    input  logic               sign_mode,
    output logic [2*WIDTH-1:0] p_next,
    output logic               last,
    output logic [SW-1:0]      shift
);

    logic [RADIX_BITS-1:0] chunk;
    logic [2*WIDTH-1:0]    pp;
    logic [WIDTH-1:0]      hi_mask;
    logic [WIDTH-1:0]      hi_bits;
    int unsigned           base;

    always_comb begin
        base    = RADIX_BITS * 32'(iter);
        chunk   = rs[base +: RADIX_BITS];
        pp      = rm_ext * {{(2*WIDTH-RADIX_BITS){1'b0}}, chunk};
        p_next  = p + (pp << base);
        shift   = SW'(base + RADIX_BITS);
        // Mask of the multiplier bits not yet consumed; empty on the last chunk.
        hi_mask = '1;
        hi_mask = hi_mask << (base + RADIX_BITS);
        hi_bits = rs & hi_mask;
        last    = (iter == IW'(N_ITER - 1)) ||
                  (hi_bits == '0) ||
                  (sign_mode && (hi_bits == hi_mask));
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative multiply / multiply-accumulate unit (MUL, MLA, UMULL, UMLAL,
// SMULL, SMLAL) with early termination on zero / sign runs.
//   start, long_i, signed_i, acc_i, set_flags_i : request and op select
//   rm, rs, acc_hi, acc_lo                      : operands
//   n, z, c, v                                  : current flags
//   busy, done                                  : status, done is a 1-cycle pulse
//   res_hi, res_lo, out_n/z/c/v                 : held result and flags
module mul_unit
    import arm_core_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             long_i,
    input  logic             signed_i,
    input  logic             acc_i,
    input  logic             set_flags_i,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic             n,
    input  logic             z,
    input  logic             c,
    input  logic             v,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v
);

    localparam int unsigned N_ITER = WIDTH / RADIX_BITS;
    localparam int unsigned IW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int unsigned SW     = $clog2(WIDTH + 1);

    mul_state_t         state, state_nx;
    logic [2*WIDTH-1:0] p_q, rm_ext_q, p_next, p_fin;
    logic [WIDTH-1:0]   rs_q, acc_hi_sel;
    logic [IW-1:0]      iter_q;
    logic [SW-1:0]      shift, shift_q;
    logic               long_q, sign_q, sflags_q, tail_q, last;
    logic               n_q, z_q, c_q, v_q;
    logic               sign_mode_in;
    logic [2*WIDTH-1:0] rm_ext_in;

    mul_step #(.WIDTH(WIDTH), .RADIX_BITS(RADIX_BITS)) u_step (
        .p         (p_q),
        .rm_ext    (rm_ext_q),
        .rs        (rs_q),
        .iter      (iter_q),
        .sign_mode (sign_q),
        .p_next    (p_next),
        .last      (last),
        .shift     (shift)
    );

    always_comb begin
        sign_mode_in = !long_i || signed_i;
        acc_hi_sel   = long_i ? acc_hi : '0;
        rm_ext_in    = (sign_mode_in && long_i) ? {{WIDTH{rm[WIDTH-1]}}, rm}
                                                : {{WIDTH{1'b0}}, rm};
        // The chunks were summed as unsigned; a set sign bit in rs means the
        // unconsumed upper bits (all ones) are worth -2^shift, so take it back.
        p_fin = tail_q ? (p_q - (rm_ext_q << shift_q)) : p_q;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MUL;
            MUL:     if (last)  state_nx = FINAL;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
            out_n    <= 1'b0;
            out_z    <= 1'b0;
            out_c    <= 1'b0;
            out_v    <= 1'b0;
            p_q      <= '0;
            rm_ext_q <= '0;
            rs_q     <= '0;
            iter_q   <= '0;
            shift_q  <= '0;
            long_q   <= 1'b0;
            sign_q   <= 1'b0;
            sflags_q <= 1'b0;
            tail_q   <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_q      <= acc_i ? {acc_hi_sel, acc_lo} : '0;
                        rm_ext_q <= rm_ext_in;
                        rs_q     <= rs;
                        iter_q   <= '0;
                        long_q   <= long_i;
                        sign_q   <= sign_mode_in;
                        sflags_q <= set_flags_i;
                        tail_q   <= 1'b0;
                        n_q      <= n;
                        z_q      <= z;
                        c_q      <= c;
                        v_q      <= v;
                    end
                end
                MUL: begin
                    p_q <= p_next;
                    if (last) begin
                        tail_q  <= sign_q && rs_q[WIDTH-1];
                        shift_q <= shift;
                    end else begin
                        iter_q <= iter_q + 1'b1;
                    end
                end
                FINAL: begin
                    done   <= 1'b1;
                    res_lo <= p_fin[WIDTH-1:0];
                    res_hi <= long_q ? p_fin[2*WIDTH-1:WIDTH] : '0;
                    out_c  <= c_q;
                    out_v  <= v_q;
                    if (sflags_q) begin
                        out_n <= long_q ? p_fin[2*WIDTH-1] : p_fin[WIDTH-1];
                        out_z <= long_q ? (p_fin == '0) : (p_fin[WIDTH-1:0] == '0);
                    end else begin
                        out_n <= n_q;
                        out_z <= z_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard testbench for mul_unit (WIDTH=32, RADIX_BITS=8).
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, long_i, signed_i, acc_i, set_flags_i;
    logic [31:0] rm, rs, acc_hi, acc_lo;
    logic        n, z, c, v;
    logic        busy, done;
    logic [31:0] res_hi, res_lo;
    logic        out_n, out_z, out_c, out_v;

    always #5 clk = ~clk;

    mul_unit #(.WIDTH(32), .RADIX_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .long_i      (long_i),
        .signed_i    (signed_i),
        .acc_i       (acc_i),
        .set_flags_i (set_flags_i),
        .rm          (rm),
        .rs          (rs),
        .acc_hi      (acc_hi),
        .acc_lo      (acc_lo),
        .n           (n),
        .z           (z),
        .c           (c),
        .v           (v),
        .busy        (busy),
        .done        (done),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .out_n       (out_n),
        .out_z       (out_z),
        .out_c       (out_c),
        .out_v       (out_v)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  f;      // {N,Z,C,V}
        longint      lat;    // edges from accept to done
        longint      t_issue;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"},  64'(res_hi), 64'(mon_e.hi));
                check({mon_e.name, "_lo"},  64'(res_lo), 64'(mon_e.lo));
                check({mon_e.name, "_nzcv"}, 64'({out_n, out_z, out_c, out_v}), 64'(mon_e.f));
                check({mon_e.name, "_latency"},
                      64'((longint'($time) - mon_e.t_issue - 5) / 10), 64'(mon_e.lat));
            end
        end
    end

    task automatic issue(input string nm, input logic lg, input logic sg, input logic ac,
                         input logic s, input logic [31:0] a_rm, input logic [31:0] a_rs,
                         input logic [31:0] a_hi, input logic [31:0] a_lo, input logic [3:0] fin,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic [3:0] ef,
                         input int lat, input bit push, input bit b2b);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait actual=busy required=idle", nm);
        end
        if (b2b) check({nm, "_b2b_done_cycle"}, 64'(done), 64'(1));
        long_i = lg; signed_i = sg; acc_i = ac; set_flags_i = s;
        rm = a_rm; rs = a_rs; acc_hi = a_hi; acc_lo = a_lo;
        {n, z, c, v} = fin;
        start = 1'b1;
        @(posedge clk);
        e.name = nm; e.hi = ehi; e.lo = elo; e.f = ef; e.lat = longint'(lat);
        e.t_issue = longint'($time);
        if (push) sb.push_back(e);
        #1 start = 1'b0;
    endtask

    initial begin
        int g;
        rst_n = 1'b0; start = 1'b0; long_i = 1'b0; signed_i = 1'b0; acc_i = 1'b0;
        set_flags_i = 1'b0; rm = '0; rs = '0; acc_hi = '0; acc_lo = '0;
        n = 1'b0; z = 1'b0; c = 1'b0; v = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_res_hi", 64'(res_hi), 64'(0));
        check("rst_res_lo", 64'(res_lo), 64'(0));
        check("rst_flags", 64'({out_n, out_z, out_c, out_v}), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        //      name      lg sg ac s  rm            rs            acc_hi        acc_lo        nzcv     exp_hi        exp_lo        exp    lat
        issue("mul",      0, 0, 0, 1, 32'd3,        32'd5,        32'h0,        32'h0,        4'b0010, 32'h0,        32'd15,       4'b0010, 2, 1, 0);
        issue("umull",    1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        4'b1001, 32'hFFFFFFFE, 32'h00000001, 4'b1001, 5, 1, 0);
        issue("smull",    1, 1, 0, 1, 32'd2,        32'hFFFFFFFF, 32'h0,        32'h0,        4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 2, 1, 0);
        issue("mla",      0, 0, 1, 1, 32'h00010000, 32'h00010000, 32'h1234,     32'h0,        4'b0011, 32'h0,        32'h0,        4'b0111, 4, 1, 0);
        issue("umlal",    1, 0, 1, 0, 32'd1,        32'd1,        32'h0,        32'hFFFFFFFF, 4'b0100, 32'h1,        32'h0,        4'b0100, 2, 1, 0);
        issue("smull_k4", 1, 1, 0, 1, 32'hFFFFFFFF, 32'h80000000, 32'h0,        32'h0,        4'b0101, 32'h0,        32'h80000000, 4'b0001, 5, 1, 0);
        issue("mul_neg",  0, 0, 0, 1, 32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFFF2, 4'b1000, 2, 1, 0);

        // start while busy must be ignored; result stays that of the first op
        issue("busy_ign", 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        4'b0000, 32'hFFFFFFFE, 32'h00000001, 4'b0000, 5, 1, 0);
        @(negedge clk);
        rm = 32'd0; rs = 32'd0; long_i = 1'b0; set_flags_i = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // reset in the middle of a 4-iteration op: no done, outputs cleared
        issue("abort",    1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        4'b1111, 32'h0,        32'h0,        4'b0000, 5, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_res_lo", 64'(res_lo), 64'(0));
        check("abort_res_hi", 64'(res_hi), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // back-to-back: second start is presented in the first op's done cycle
        issue("b2b_a",    1, 1, 0, 1, 32'd2,        32'hFFFFFFFF, 32'h0,        32'h0,        4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1010, 2, 1, 0);
        issue("b2b_b",    0, 0, 0, 0, 32'h100,      32'h100,      32'h0,        32'h0,        4'b1111, 32'h0,        32'h00010000, 4'b1111, 3, 1, 1);

        g = 0;
        while (sb.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", sb.size());
        end
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multiply / multiply-accumulate unit for the ARMv4 core, sitting beside the data-processing ALU in the execute stage. It executes MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. Each cycle it consumes RADIX_BITS bits of the multiplier and terminates early on sign/zero runs, which gives ARM7-style variable latency. Flags are produced in the same N/Z/C/V convention as the ALU.

## Interface
- WIDTH, 32: operand width; must be a multiple of RADIX_BITS and at least 8.
- RADIX_BITS, 8: multiplier bits consumed per iteration; N_ITER = WIDTH/RADIX_BITS.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- long_i  in  1  1 = 2·WIDTH result (xMULL/xMLAL)
- signed_i  in  1  signed long multiply (ignored when long_i=0)
- acc_i  in  1  accumulate
- set_flags_i  in  1  S bit
- rm  in  WIDTH  multiplicand
- rs  in  WIDTH  multiplier
- acc_hi, acc_lo  in  WIDTH each  accumulator (acc_hi used only when long_i=1)
- n, z, c, v  in  1 each  current flags
- busy  out  1  operation in flight
- done  out  1  one-cycle result-valid pulse
- res_hi, res_lo  out  WIDTH each  result (res_hi=0 for short ops)
- out_n, out_z, out_c, out_v  out  1 each  resulting flags

## Operation
- States: IDLE, MUL, FINAL.
- IDLE + start: capture all inputs.
  - P (2·WIDTH) := acc_i ? {long_i ? acc_hi : 0, acc_lo} : 0.
  - i := 0. Go to MUL.
- sign_mode = !long_i | signed_i. Short MUL uses signed termination; the low word is unaffected.
- rm_ext = sign_mode & long_i ? sign-extend(rm) : zero-extend(rm), to 2·WIDTH.
- MUL, iteration i:
  - P += rm_ext × unsigned(rs chunk i) << (RADIX_BITS·i), modulo 2^(2·WIDTH).
  - Terminate when any of the following holds: i = N_ITER−1; rs bits above RADIX_BITS·(i+1) are all zero; or sign_mode and those bits are all ones.
  - Otherwise i += 1.
  - On termination, latch tail = sign_mode & rs[WIDTH−1] and shift s = RADIX_BITS·(i+1), then go to FINAL.
- FINAL:
  - If tail, P −= rm_ext << s.
  - Register results: res_lo = P[WIDTH−1:0], res_hi = long ? P[2W−1:W] : 0.
  - Pulse done and return to IDLE.
- Flags, when set_flags_i=1:
  - out_n = MSB of the result (P[2W−1] long, P[W−1] short).
  - out_z = entire result zero.
  - out_c = captured c (decided: preserved). out_v = captured v.
- Flags, when set_flags_i=0: all four flags equal the captured inputs.
- start while busy=1 is ignored; captured operands cannot change mid-operation.

## Timing
- Reset (async, asserted): state=IDLE, busy=0, done=0, res_hi=res_lo=0, all out_* flags=0.
- Reset mid-operation: operation aborted and no done is issued.
- k = number of MUL iterations, 1 ≤ k ≤ N_ITER.
- Sequence from accept edge E0:
  - busy=1 from after E0 through the FINAL cycle.
  - MUL cycles are edges E1..Ek.
  - FINAL executes at E(k+1); done=1 and busy=0 for the cycle after E(k+1).
- Latency is k+1 edges. WIDTH=32/RADIX_BITS=8 gives 2..5.
- start asserted in the done cycle is accepted, so back-to-back issue has no bubble.
- res_* and out_* hold their values after done until the next FINAL.
- No accumulate or long-multiply penalty cycles.

## Structure
- Shared package arm_core_pkg holds:
  - the mul_state_t enum (IDLE/MUL/FINAL);
  - the opcode-bit constants for the long/signed/accumulate/S fields, shared with the decoder.
- One combinational sub-module, mul_step: the WIDTH×RADIX_BITS partial product, shift and 2·WIDTH add, plus the termination detect for chunk i.
- The top level holds the FSM, operand/flag capture and the FINAL correction/flag logic.

## Test plan
All scenarios use WIDTH=32, RADIX_BITS=8.
- MUL, S=1, rm=3, rs=5 → k=1, done 2 edges after accept; res_lo=15, res_hi=0, N=0, Z=0, C/V equal the inputs.
- UMULL, rm=rs=0xFFFFFFFF → k=4, done after 5 edges; res_hi=0xFFFFFFFE, res_lo=0x00000001.
- SMULL, S=1, rm=2, rs=0xFFFFFFFF → k=1 (ones-run) with tail correction; res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFE, N=1, Z=0.
- MLA, S=1, rm=rs=0x00010000, acc_lo=0, c=1, v=1 → k=3; res_lo=0, Z=1, N=0, C=1, V=1.
- UMLAL, rm=1, rs=1, acc_hi=0, acc_lo=0xFFFFFFFF → k=1; res_hi=1, res_lo=0.
- Control:
  - start pulsed while busy → ignored, original result unchanged.
  - rst_n low at E2 of a 4-iteration op → busy=0 and no done.
  - New start in the done cycle → accepted, and its done arrives k+1 edges later.
